fpu_op_issuer: RTL
==================

Name: fpu_op_issuer

Overview:
- Sequential initiator for the combinational FPU datapath (num1/num2/op in, result out).
- Accepts tagged FP commands over a valid/ready interface and buffers them in a small FIFO.
- Drives them one at a time onto FPU operand/op registers, samples the result after a fixed settle time, and returns result, tag and classification flags over a valid/ready response interface.
- Sits between the instruction/control path and the FPU core.

Parameters:
SETTLE_CYCLES, 1, cycles from FPU operand register load to result capture; legal range 1..15.
QDEPTH, 4, command FIFO depth; power of two, 2..16.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  FIFO can accept a command.
cmd_num1  input  32  operand 1, IEEE 754 single.
cmd_num2  input  32  operand 2, IEEE 754 single.
cmd_op  input  4  0=ADD, 1=SUB, 2=MUL; any other value is unsupported.
cmd_tag  input  4  opaque tag, returned with the response.
fpu_num1  output  32  registered operand 1 to FPU.
fpu_num2  output  32  registered operand 2 to FPU.
fpu_op  output  4  registered op to FPU.
fpu_result  input  32  FPU result, combinational from fpu_*.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts response.
rsp_result  output  32  captured result.
rsp_tag  output  4  tag of the completed command.
rsp_flags  output  4  [3]=NaN, [2]=Inf, [1]=Zero, [0]=unsupported op.
busy  output  1  high when FIFO non-empty or FSM not IDLE.
done_cnt  output  16  count of completed responses; wraps.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty, state IDLE.
  - cmd_ready=1; rsp_valid=0; busy=0.
  - All data outputs, tag, flags and done_cnt = 0.
  - In-flight and queued commands are discarded; rsp_valid drops immediately.
- Command FIFO:
  - Push on cmd_valid&cmd_ready.
  - cmd_ready = !full, derived from registered occupancy (no combinational path from cmd_valid).
  - Push and pop in the same cycle are legal; occupancy is unchanged.
  - When full, cmd_ready=0 and cmd_valid is ignored.
  - Pointers wrap modulo QDEPTH.
- FSM states: IDLE, WAIT, RESP.
  - IDLE, FIFO non-empty: pop head, load fpu_num1/fpu_num2/fpu_op and an internal tag register at the edge, load settle counter = SETTLE_CYCLES, go to WAIT.
  - WAIT: counter decrements each cycle. At the edge where it reaches 0, capture into rsp_result and rsp_flags, set rsp_valid=1, go to RESP.
    - Capture happens SETTLE_CYCLES edges after the fpu_* load.
  - RESP: hold rsp_* stable while rsp_valid&!rsp_ready.
    - On handshake: done_cnt += 1 (16-bit wrap, 0xFFFF→0x0000).
    - If FIFO non-empty at that edge, pop next and load fpu_* at the same edge (back-to-back), go to WAIT, rsp_valid=0 next cycle.
    - Otherwise go to IDLE with rsp_valid=0.
- Latency: empty FIFO, command accepted at edge A gives fpu_* loaded at A+1 and rsp_valid high after edge A+1+SETTLE_CYCLES.
- Steady-state throughput: one command per SETTLE_CYCLES+1 cycles with rsp_ready tied high.
- fpu_* hold their last value outside loads and are never cleared except by reset.
- Unsupported op (cmd_op > 2):
  - The command still passes through WAIT; timing is identical.
  - rsp_result is forced to 32'h7FC00000 instead of fpu_result.
  - flags[0]=1.
- Flags are computed on the value captured into rsp_result:
  - NaN: exp=8'hFF and mantissa≠0.
  - Inf: exp=8'hFF and mantissa=0.
  - Zero: exp=0 and mantissa=0, either sign.
  - Denormals raise no flag.
- busy = (occupancy≠0) | (state≠IDLE).

Test Plan:
- SETTLE_CYCLES=1, real FPU attached: ADD 3F800000+40000000 tag 5 → rsp_result=40400000, tag=5, flags=0000, rsp_valid on the 2nd edge after acceptance.
- MUL 40000000*40400000 tag 2, then SUB 40400000-40400000 tag 3, rsp_ready=1 → 40C00000/flags 0000, then 00000000/flags 0010, in order; done_cnt=2.
- op=3 with any operands → rsp_result=7FC00000, flags=1001, same latency as ADD.
- Hold rsp_ready=0 and push QDEPTH+1 commands → cmd_ready drops after QDEPTH+1 accepted (one in flight plus QDEPTH queued); rsp_* stable; release → responses drain in order, tags match.
- Assert rst_n=0 mid-WAIT with 2 queued commands → rsp_valid=0 and busy=0 immediately, cmd_ready=1; after release, no stale response appears.
- Preload done_cnt to FFFF via 65535 completions → the next handshake gives done_cnt=0000.

Source files
------------

// File: rtl/fpu_op_issuer_if.sv
// Command/response handshake bundle between a requester and fpu_op_issuer.
//   cmd_*  : tagged FP command (valid/ready), requester -> issuer
//   rsp_*  : result, tag and flags (valid/ready), issuer -> requester
// master = requester side, slave = issuer side.
interface fpu_op_issuer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_num1;
  logic [31:0] cmd_num2;
  logic [3:0]  cmd_op;
  logic [3:0]  cmd_tag;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic [3:0]  rsp_flags;

  modport master (
    output cmd_valid, cmd_num1, cmd_num2, cmd_op, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_tag, rsp_flags
  );

  modport slave (
    input  cmd_valid, cmd_num1, cmd_num2, cmd_op, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_tag, rsp_flags
  );
endinterface

// File: rtl/fpu_op_issuer.sv
// Sequential initiator for a combinational FPU datapath.
// Buffers tagged commands in a QDEPTH-entry FIFO, drives them one at a time
// onto registered FPU operand/op outputs, captures the FPU result
// SETTLE_CYCLES edges later and returns result, tag and class flags.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   link (slave)        : cmd_* command and rsp_* response handshakes
//   fpu_num1/num2/op    : registered operands/op to the FPU
//   fpu_result          : combinational FPU result
//   busy                : FIFO non-empty or sequencer active
//   done_cnt            : completed responses, wraps at 16 bits
// rsp_flags = {NaN, Inf, Zero, unsupported op}.
module fpu_op_issuer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned QDEPTH        = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  fpu_op_issuer_if.slave link,
  output logic [31:0]    fpu_num1,
  output logic [31:0]    fpu_num2,
  output logic [3:0]     fpu_op,
  input  logic [31:0]    fpu_result,
  output logic           busy,
  output logic [15:0]    done_cnt
);

  localparam int unsigned PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW   = PW + 1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [31:0] num1;
    logic [31:0] num2;
    logic [3:0]  op;
    logic [3:0]  tag;
  } cmd_t;

  state_t        state, state_n;
  cmd_t          fifo_mem [QDEPTH];
  cmd_t          head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop, capture, rsp_hs;
  logic [3:0]    settle_cnt;
  logic [3:0]    tag_q;
  logic [31:0]   cap_result;
  logic [3:0]    cap_flags;
  logic          unsupported;

  // ---------------- command FIFO ----------------
  assign full           = (count == CW'(QDEPTH));
  assign empty          = (count == '0);
  assign link.cmd_ready = !full;
  assign push           = link.cmd_valid && !full;
  assign head           = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{num1: link.cmd_num1, num2: link.cmd_num2,
                            op: link.cmd_op, tag: link.cmd_tag};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- sequencer ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Response handshake and the next pop share one edge, so a queued command
  // goes straight from RESP to WAIT without an IDLE bubble.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    capture = 1'b0;
    rsp_hs  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        // Count reaches zero on this edge.
        if (settle_cnt == 4'd1) begin
          capture = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        if (link.rsp_ready) begin
          rsp_hs = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            state_n = WAIT;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               settle_cnt <= '0;
    else if (pop)             settle_cnt <= 4'(SETTLE_CYCLES);
    else if (state == WAIT)   settle_cnt <= settle_cnt - 4'd1;
  end

  // ---------------- result capture and classification ----------------
  always_comb begin
    unsupported  = (fpu_op > 4'd2);
    cap_result   = unsupported ? QNAN : fpu_result;
    cap_flags    = '0;
    cap_flags[3] = (cap_result[30:23] == 8'hFF) && (cap_result[22:0] != '0);
    cap_flags[2] = (cap_result[30:23] == 8'hFF) && (cap_result[22:0] == '0);
    cap_flags[1] = (cap_result[30:23] == 8'h00) && (cap_result[22:0] == '0);
    cap_flags[0] = unsupported;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpu_num1        <= '0;
      fpu_num2        <= '0;
      fpu_op          <= '0;
      tag_q           <= '0;
      link.rsp_result <= '0;
      link.rsp_tag    <= '0;
      link.rsp_flags  <= '0;
      done_cnt        <= '0;
    end else begin
      if (pop) begin
        fpu_num1 <= head.num1;
        fpu_num2 <= head.num2;
        fpu_op   <= head.op;
        tag_q    <= head.tag;
      end
      if (capture) begin
        link.rsp_result <= cap_result;
        link.rsp_flags  <= cap_flags;
        link.rsp_tag    <= tag_q;
      end
      if (rsp_hs) done_cnt <= done_cnt + 16'd1;
    end
  end

  assign link.rsp_valid = (state == RESP);
  assign busy           = !empty || (state != IDLE);

endmodule
